// File: rtl/sram_mem_controller.sv
// sram_mem_controller: data-memory responder for the MEM stage. Each 32-bit
// load/store becomes two 16-bit SRAM accesses (low half, then high half), each
// held for WAIT_CYCLES+1 cycles. ready low freezes the pipeline.
// Optional feature macro: SRAM_STALL_COUNT_EN adds a free-running count of
// cycles spent with ready low on port stall_count.
module sram_mem_controller #(
   parameter int          SRAM_ADDR_WIDTH = 18,
   parameter int          WAIT_CYCLES     = 2,
   parameter logic [31:0] BASE_ADDR       = 32'd1024
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       rd_en,
   input  logic                       wr_en,
   input  logic [31:0]                address,
   input  logic [31:0]                write_data,
   output logic [31:0]                read_data,
   output logic                       ready,
   output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
   output logic [15:0]                sram_dq_out,
   input  logic [15:0]                sram_dq_in,
   output logic                       sram_dq_oe,
   output logic                       sram_we_n
`ifdef SRAM_STALL_COUNT_EN
   ,
   output logic [31:0]                stall_count
`endif
);

   localparam int         IW   = SRAM_ADDR_WIDTH - 1;
   localparam logic [2:0] LAST = 3'(WAIT_CYCLES);

   typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_DONE} state_t;

   state_t        state_q, state_d;
   logic [2:0]    cnt_q, cnt_d;
   logic          op_wr_q;
   logic [IW-1:0] idx_q;
   logic [31:0]   wdata_q;
   logic [31:0]   rdata_q;

   logic          req;
   logic          last_cyc;
   logic          we_window;
   logic [31:0]   offset;
   logic [IW-1:0] idx_d;
   logic          unused_offset_bits;

   assign req       = rd_en | wr_en;
   assign last_cyc  = (cnt_q == LAST);
   // Strobe is released on the last cycle of a phase so data/address are
   // stable at the rising edge of we_n; with no wait states there is only one
   // cycle, so the strobe covers it.
   assign we_window = (WAIT_CYCLES == 0) || !last_cyc;

   // Byte offset from the SRAM window; anything below BASE_ADDR simply wraps.
   assign offset             = address - BASE_ADDR;
   assign idx_d              = offset[SRAM_ADDR_WIDTH:2];
   assign unused_offset_bits = ^{offset[31:SRAM_ADDR_WIDTH+1], offset[1:0]};

   assign read_data = rdata_q;

   // State register and wait-state counter
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 3'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic: each half phase lasts until the counter reaches LAST
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            cnt_d = 3'd0;
            if (req) state_d = S_LO;
         end
         S_LO: begin
            if (last_cyc) begin
               state_d = S_HI;
               cnt_d   = 3'd0;
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
         S_HI: begin
            if (last_cyc) begin
               state_d = S_DONE;
               cnt_d   = 3'd0;
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Request capture: a simultaneous read and write is treated as a write
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         op_wr_q <= 1'b0;
         idx_q   <= '0;
         wdata_q <= 32'd0;
      end else if (state_q == S_IDLE && req) begin
         op_wr_q <= wr_en;
         idx_q   <= idx_d;
         wdata_q <= write_data;
      end
   end

   // Load data: each half is sampled on the final edge of its phase
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rdata_q <= 32'd0;
      end else if (!op_wr_q && last_cyc) begin
         if (state_q == S_LO) rdata_q[15:0]  <= sram_dq_in;
         if (state_q == S_HI) rdata_q[31:16] <= sram_dq_in;
      end
   end

   // Output decode: pipeline handshake and SRAM pin control per state
   always_comb begin
      ready       = 1'b0;
      sram_addr   = '0;
      sram_dq_out = 16'd0;
      sram_dq_oe  = 1'b0;
      sram_we_n   = 1'b1;
      case (state_q)
         S_IDLE: ready = ~req;
         S_LO: begin
            sram_addr   = {idx_q, 1'b0};
            sram_dq_out = wdata_q[15:0];
            sram_dq_oe  = op_wr_q;
            sram_we_n   = ~(op_wr_q & we_window);
         end
         S_HI: begin
            sram_addr   = {idx_q, 1'b1};
            sram_dq_out = wdata_q[31:16];
            sram_dq_oe  = op_wr_q;
            sram_we_n   = ~(op_wr_q & we_window);
         end
         S_DONE:  ready = 1'b1;
         default: ready = 1'b0;
      endcase
   end

`ifdef SRAM_STALL_COUNT_EN
   logic [31:0] stall_q;

   // Count every cycle the pipeline is frozen; wraps naturally at 2^32
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)        stall_q <= 32'd0;
      else if (!ready) stall_q <= stall_q + 32'd1;
   end

   assign stall_count = stall_q;
`endif

endmodule
